// File: rtl/segment7_decoder.sv
// Recovers a hex digit from an active-low 7-segment pattern after STABLE_CYCLES of stability; result valid STABLE_CYCLES+1 clocks
// after a new pattern appears and is held (frozen) until Out_Ready. Optional SEG_DECODE_ERRCNT_EN adds a saturating error counter.
module segment7_decoder #(
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 5
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [6:0] Seg_In,
    input  logic       Out_Ready,
    output logic [3:0] Hex_Out,
    output logic       Hex_Valid,
    output logic       Hex_Error
`ifdef SEG_DECODE_ERRCNT_EN
    ,
    output logic [7:0] Err_Count
`endif
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_SETTLE   = 2'd1;
    localparam logic [1:0] S_HOLD     = 2'd2;
    localparam logic [1:0] S_WAIT_CHG = 2'd3;

    localparam logic [6:0]       BLANK   = 7'h7F;
    localparam logic [CNT_W-1:0] CNT_TGT = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       state;
    logic [6:0]       seg_q;
    logic [6:0]       acc_q;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       dec_hex;
    logic             dec_err;
    logic             stable;
    logic             settled;
    logic             is_blank;
    logic             accept;
    logic             new_pattern;

    always_comb begin
        dec_hex = 4'h0;
        dec_err = 1'b0;
        case (Seg_In)
            7'h40: dec_hex = 4'h0;
            7'h79: dec_hex = 4'h1;
            7'h24: dec_hex = 4'h2;
            7'h30: dec_hex = 4'h3;
            7'h19: dec_hex = 4'h4;
            7'h12: dec_hex = 4'h5;
            7'h02: dec_hex = 4'h6;
            7'h78: dec_hex = 4'h7;
            7'h00: dec_hex = 4'h8;
            7'h10: dec_hex = 4'h9;
            7'h08: dec_hex = 4'hA;
            7'h03: dec_hex = 4'hB;
            7'h46: dec_hex = 4'hC;
            7'h21: dec_hex = 4'hD;
            7'h06: dec_hex = 4'hE;
            7'h0E: dec_hex = 4'hF;
            default: dec_err = 1'b1;
        endcase
    end

    assign is_blank    = (Seg_In == BLANK);
    assign stable      = (Seg_In == seg_q);
    assign settled     = stable && (cnt == CNT_TGT);
    assign accept      = (state == S_HOLD) && Out_Ready;
    assign new_pattern = (state == S_WAIT_CHG) && (Seg_In != acc_q) && !is_blank;

    // The sample register and counter run in every state; leaving WAIT_CHG
    // for a fresh pattern forces a clean count even if it matched seg_q.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            seg_q <= BLANK;
            cnt   <= '0;
        end else begin
            seg_q <= Seg_In;
            if (new_pattern || !stable)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state     <= S_IDLE;
            acc_q     <= BLANK;
            Hex_Out   <= 4'h0;
            Hex_Valid <= 1'b0;
            Hex_Error <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!is_blank)
                        state <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (settled) begin
                        if (is_blank) begin
                            state <= S_IDLE;
                        end else begin
                            Hex_Out   <= dec_err ? 4'h0 : dec_hex;
                            Hex_Error <= dec_err;
                            acc_q     <= Seg_In;
                            Hex_Valid <= 1'b1;
                            state     <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (Out_Ready) begin
                        Hex_Valid <= 1'b0;
                        state     <= S_WAIT_CHG;
                    end
                end
                default: begin
                    if (Seg_In != acc_q)
                        state <= is_blank ? S_IDLE : S_SETTLE;
                end
            endcase
        end
    end

`ifdef SEG_DECODE_ERRCNT_EN
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)
            Err_Count <= 8'h00;
        else if (accept && Hex_Error && (Err_Count != 8'hFF))
            Err_Count <= Err_Count + 8'h01;
    end
`endif

endmodule

// File: tb/tb_segment7_decoder.sv
// Directed and randomized checks of segment7_decoder against a table/latency reference model.
module tb_segment7_decoder;

    localparam int S = 4;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [6:0] Seg_In;
    logic       Out_Ready;
    logic [3:0] Hex_Out;
    logic       Hex_Valid;
    logic       Hex_Error;
`ifdef SEG_DECODE_ERRCNT_EN
    logic [7:0] Err_Count;
`endif

    int checks = 0;
    int errors = 0;
    int exp_errcnt = 0;

    logic [6:0] digit_pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    segment7_decoder #(.STABLE_CYCLES(S), .CNT_W(5)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Seg_In    (Seg_In),
        .Out_Ready (Out_Ready),
        .Hex_Out   (Hex_Out),
        .Hex_Valid (Hex_Valid),
        .Hex_Error (Hex_Error)
`ifdef SEG_DECODE_ERRCNT_EN
        ,
        .Err_Count (Err_Count)
`endif
    );

    always #5 Clk = ~Clk;

    // Index of the digit whose segment pattern matches, or -1 if unrecognised.
    function automatic int ref_digit(input logic [6:0] p);
        int r = -1;
        for (int i = 0; i < 16; i++)
            if (digit_pat[i] == p) r = i;
        return r;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic count_valid(input int n, output int hits);
        hits = 0;
        for (int k = 0; k < n; k++) begin
            step(1);
            if (Hex_Valid) hits++;
        end
    endtask

    // Present pattern p after a blank, expect one result S+1 edges later,
    // optionally stall the consumer, then accept and expect no repeat.
    task automatic run_pattern(input logic [6:0] p, input int stall);
        int idx;
        int hits;
        int bad;
        idx = ref_digit(p);
        Seg_In = 7'h7F;
        Out_Ready = 1'b1;
        step(3);
        Seg_In = p;
        Out_Ready = (stall == 0);
        count_valid(S, hits);
        chk("early_valid", hits, 0);
        step(1);
        chk("valid", Hex_Valid, 1);
        chk("hex", Hex_Out, (idx < 0) ? 0 : idx);
        chk("error", Hex_Error, (idx < 0) ? 1 : 0);
        if (stall > 0) begin
            bad = 0;
            for (int k = 0; k < stall; k++) begin
                step(1);
                if (!Hex_Valid || Hex_Out !== 4'((idx < 0) ? 0 : idx)) bad++;
            end
            chk("stall_hold", bad, 0);
            Out_Ready = 1'b1;
        end
        step(1);
        chk("accepted", Hex_Valid, 0);
        if (idx < 0 && exp_errcnt < 255) exp_errcnt++;
`ifdef SEG_DECODE_ERRCNT_EN
        chk("err_count", Err_Count, exp_errcnt);
`endif
        count_valid(2 * S, hits);
        chk("no_repeat", hits, 0);
    endtask

    initial begin
        int hits;
        logic [6:0] p;

        Rst = 1'b0;
        Seg_In = 7'h7F;
        Out_Ready = 1'b1;
        #2;
        chk("rst_valid", Hex_Valid, 0);
        chk("rst_hex", Hex_Out, 0);
        chk("rst_error", Hex_Error, 0);
`ifdef SEG_DECODE_ERRCNT_EN
        chk("rst_errcnt", Err_Count, 0);
`endif
        step(2);
        Rst = 1'b1;

        count_valid(3 * S, hits);
        chk("blank_never_valid", hits, 0);

        run_pattern(7'h24, 0);

        // Counter restarts when the pattern changes mid-settle.
        Seg_In = 7'h7F;
        step(3);
        Seg_In = 7'h00;
        count_valid(2, hits);
        Seg_In = 7'h10;
        begin
            int h2;
            count_valid(S, h2);
            chk("toggle_early", hits + h2, 0);
        end
        step(1);
        chk("toggle_valid", Hex_Valid, 1);
        chk("toggle_hex", Hex_Out, 9);
        step(1);
        chk("toggle_accepted", Hex_Valid, 0);

        // Output frozen under backpressure while the input moves on.
        Seg_In = 7'h7F;
        step(3);
        Out_Ready = 1'b0;
        Seg_In = 7'h0E;
        step(S + 1);
        chk("bp_valid", Hex_Valid, 1);
        Seg_In = 7'h40;
        begin
            int bad = 0;
            for (int k = 0; k < 10; k++) begin
                step(1);
                if (!Hex_Valid || Hex_Out !== 4'hF) bad++;
            end
            chk("bp_frozen", bad, 0);
        end
        Out_Ready = 1'b1;
        step(1);
        chk("bp_accepted", Hex_Valid, 0);
        count_valid(S, hits);
        chk("bp_next_early", hits, 0);
        step(1);
        chk("bp_next_valid", Hex_Valid, 1);
        chk("bp_next_hex", Hex_Out, 0);

        // Same digit twice separated by blank gives two results.
        run_pattern(7'h79, 0);
        run_pattern(7'h79, 0);

        run_pattern(7'h55, 0);

        for (int t = 0; t < 20; t++) begin
            if ($urandom_range(0, 1) == 1)
                p = digit_pat[$urandom_range(0, 15)];
            else
                p = 7'($urandom_range(0, 126));
            run_pattern(p, $urandom_range(0, 3));
        end

        for (int t = 0; t < 300; t++) begin
            do p = 7'($urandom_range(0, 126)); while (ref_digit(p) >= 0);
            run_pattern(p, 0);
        end

        // Asynchronous reset during HOLD discards the pending result.
        Seg_In = 7'h7F;
        Out_Ready = 1'b1;
        step(3);
        Out_Ready = 1'b0;
        Seg_In = 7'h24;
        step(S + 1);
        chk("pre_rst_valid", Hex_Valid, 1);
        #2;
        Rst = 1'b0;
        #1;
        chk("arst_valid", Hex_Valid, 0);
        chk("arst_hex", Hex_Out, 0);
        chk("arst_error", Hex_Error, 0);
        exp_errcnt = 0;
`ifdef SEG_DECODE_ERRCNT_EN
        chk("arst_errcnt", Err_Count, 0);
`endif
        #1;
        Rst = 1'b1;
        count_valid(S, hits);
        chk("post_rst_early", hits, 0);
        step(1);
        chk("post_rst_valid", Hex_Valid, 1);
        chk("post_rst_hex", Hex_Out, 2);
        Out_Ready = 1'b1;
        step(1);
        chk("post_rst_accepted", Hex_Valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
